// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: request/response data-memory controller for a RV32 core.
// Accepts one load/store at a time, inserts WAIT_STATES idle cycles, then
// performs the access and presents a one-cycle response.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE   | ready for a new request (req_ready=1)
// ST_WAIT   | counting down inserted wait states
// ST_ACCESS | memory read/write; rd/fault registered at end of cycle
// ST_RESP   | resp_valid=1, rd/fault presented
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    request handshake
//   MemRead, MemWrite        load/store request (store wins if both set)
//   a, wd, Funct3            byte address, store data, size/sign
//   rd, fault, resp_valid    registered load data, fault flag, response pulse
module data_mem_ctrl #(
  parameter int DM_ADDRESS  = 9,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [DM_ADDRESS-1:0] a,
  input  logic [31:0]           wd,
  input  logic [2:0]            Funct3,
  output logic [31:0]           rd,
  output logic                  resp_valid,
  output logic                  fault
);

  localparam int         DEPTH = 2 ** (DM_ADDRESS - 2);
  localparam logic [2:0] WS    = 3'(WAIT_STATES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_RESP} state_t;

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [DM_ADDRESS-1:0] addr_q, addr_d;
  logic [31:0]           wd_q, wd_d;
  logic [2:0]            f3_q, f3_d;
  logic                  is_wr_q, is_wr_d;
  logic [31:0]           rd_q, rd_d;
  logic                  fault_q, fault_d;

  logic [31:0] mem [DEPTH];

  logic [DM_ADDRESS-3:0] word_idx;
  logic [1:0]            lane;
  logic [31:0]           mem_word;
  logic [31:0]           shifted;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic                  legal;
  logic                  misaligned;
  logic                  bad;
  logic                  wr_en;
  logic [3:0]            be;
  logic [31:0]           wdata;

  assign word_idx = addr_q[DM_ADDRESS-1:2];
  assign lane     = addr_q[1:0];
  assign mem_word = mem[word_idx];
  assign shifted  = mem_word >> {lane, 3'b000};
  assign byte_sel = shifted[7:0];
  assign half_sel = addr_q[1] ? mem_word[31:16] : mem_word[15:0];

  // Stores only support SB/SH/SW; loads additionally allow LBU/LHU.
  assign legal = is_wr_q ? (f3_q == 3'b000 || f3_q == 3'b001 || f3_q == 3'b010)
                         : (f3_q == 3'b000 || f3_q == 3'b001 || f3_q == 3'b010 ||
                            f3_q == 3'b100 || f3_q == 3'b101);
  assign misaligned = (f3_q[1:0] == 2'b01 && lane[0]) ||
                      (f3_q[1:0] == 2'b10 && lane != 2'b00);
  assign bad = !legal || misaligned;

  // Lane enables and lane-replicated store data.
  always_comb begin
    be    = 4'b0000;
    wdata = wd_q;
    case (f3_q[1:0])
      2'b00: begin
        be    = 4'b0001 << lane;
        wdata = {4{wd_q[7:0]}};
      end
      2'b01: begin
        be    = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata = {2{wd_q[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    f3_d    = f3_q;
    is_wr_d = is_wr_q;
    rd_d    = rd_q;
    fault_d = fault_q;
    wr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && (MemRead || MemWrite)) begin
          addr_d  = a;
          wd_d    = wd;
          f3_d    = Funct3;
          is_wr_d = MemWrite;
          cnt_d   = WS;
          state_d = (WS == 3'd0) ? ST_ACCESS : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        fault_d = bad;
        rd_d    = 32'd0;
        wr_en   = is_wr_q && !bad;
        if (!is_wr_q && !bad) begin
          case (f3_q)
            3'b000:  rd_d = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  rd_d = {{16{half_sel[15]}}, half_sel};
            3'b100:  rd_d = {24'd0, byte_sel};
            3'b101:  rd_d = {16'd0, half_sel};
            default: rd_d = mem_word;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= '0;
      wd_q    <= 32'd0;
      f3_q    <= 3'd0;
      is_wr_q <= 1'b0;
      rd_q    <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      f3_q    <= f3_d;
      is_wr_q <= is_wr_d;
      rd_q    <= rd_d;
      fault_q <= fault_d;
    end
  end

  // No reset on the array; rst only blocks a pending write so an aborted
  // request leaves memory untouched.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign rd         = rd_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

  localparam int WS  = 3;
  localparam int LAT = WS + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        MemRead;
  logic        MemWrite;
  logic [8:0]  a;
  logic [31:0] wd;
  logic [2:0]  Funct3;
  logic [31:0] rd;
  logic        resp_valid;
  logic        fault;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m [128];

  always #5 clk = ~clk;

  data_mem_ctrl #(.DM_ADDRESS(9), .WAIT_STATES(WS)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .MemRead(MemRead), .MemWrite(MemWrite), .a(a), .wd(wd), .Funct3(Funct3),
    .rd(rd), .resp_valid(resp_valid), .fault(fault)
  );

  typedef struct {
    logic        rdop;
    logic        wrop;
    logic [2:0]  f3;
    logic [8:0]  addr;
    logic [31:0] wdat;
    logic [31:0] exp_rd;
    logic        exp_flt;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: memory as an array of words, lanes picked with arithmetic.
  task automatic model_op(input logic rdop, input logic wrop, input logic [2:0] f3,
                          input logic [8:0] addr, input logic [31:0] wdat,
                          output logic [31:0] exp_rd, output logic exp_flt);
    int unsigned widx = addr / 4;
    int unsigned lane = addr % 4;
    int unsigned size = f3 % 4;
    logic [31:0] w = mem_m[widx];
    logic [31:0] v, mask;
    bit legal, aligned;
    legal   = wrop ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
    aligned = (size == 0) || (size == 1 && addr % 2 == 0) || (size == 2 && addr % 4 == 0);
    exp_rd  = 32'd0;
    exp_flt = !(legal && aligned);
    if (!exp_flt) begin
      if (wrop) begin
        if (size == 2) mem_m[widx] = wdat;
        else begin
          mask = (size == 0 ? 32'hFF : 32'hFFFF) << (8 * lane);
          mem_m[widx] = (w & ~mask) | ((wdat << (8 * lane)) & mask);
        end
      end else begin
        v = w >> (8 * lane);
        case (f3)
          3'd0: exp_rd = (v % 256 >= 128) ? (v % 256) + 32'hFFFFFF00 : v % 256;
          3'd1: exp_rd = (v % 65536 >= 32768) ? (v % 65536) + 32'hFFFF0000 : v % 65536;
          3'd4: exp_rd = v % 256;
          3'd5: exp_rd = v % 65536;
          default: exp_rd = w;
        endcase
      end
    end
  endtask

  task automatic xact(input logic rdop, input logic wrop, input logic [2:0] f3,
                      input logic [8:0] addr, input logic [31:0] wdat,
                      output logic [31:0] rdo, output logic flt, output int lat);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; MemRead = rdop; MemWrite = wrop;
    Funct3 = f3; a = addr; wd = wdat;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    lat = -1; rdo = 32'hx; flt = 1'bx;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      if (resp_valid) begin
        lat = k; rdo = rd; flt = fault;
        break;
      end
    end
  endtask

  task automatic add_vec(input logic r, input logic w, input logic [2:0] f3, input logic [8:0] ad,
                         input logic [31:0] d, input logic [31:0] er, input logic ef);
    vec_t v;
    v.rdop = r; v.wrop = w; v.f3 = f3; v.addr = ad; v.wdat = d; v.exp_rd = er; v.exp_flt = ef;
    vecs.push_back(v);
  endtask

  // Reset pulsed during cycle c after acceptance of a store to 0x040.
  task automatic abort_at(input int c);
    int seen = 0;
    logic [31:0] r; logic f; int l;
    @(negedge clk);
    chk("abort_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b1;
    Funct3 = 3'b010; a = 9'h040; wd = 32'hBADBAD00;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; MemWrite = 1'b0;
    for (int k = 1; k < c; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (resp_valid) seen++;
      @(negedge clk);
    end
    chk($sformatf("abort%0d_no_resp", c), 32'(seen), 32'd0);
    xact(1'b1, 1'b0, 3'b010, 9'h040, 32'd0, r, f, l);
    chk($sformatf("abort%0d_word", c), r, 32'h11111111);
    chk($sformatf("abort%0d_fault", c), 32'(f), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, er;
    logic f, ef;
    int l, op;
    logic [2:0] f3;
    logic [8:0] ad;
    logic [31:0] d;

    rst = 1'b1; req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    a = '0; wd = '0; Funct3 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rd", rd, 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);

    // Valid without an op must not be accepted.
    req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("noop_ready", 32'(req_ready), 32'd1);
      chk("noop_resp", 32'(resp_valid), 32'd0);
    end
    req_valid = 1'b0;

    add_vec(0, 1, 3'b010, 9'h010, 32'hDEADBEEF, 32'h0, 0);
    add_vec(1, 0, 3'b010, 9'h010, 32'h0, 32'hDEADBEEF, 0);
    add_vec(0, 1, 3'b000, 9'h011, 32'h000000AA, 32'h0, 0);
    add_vec(1, 0, 3'b010, 9'h010, 32'h0, 32'hDEADAAEF, 0);
    add_vec(1, 0, 3'b000, 9'h011, 32'h0, 32'hFFFFFFAA, 0);
    add_vec(1, 0, 3'b100, 9'h011, 32'h0, 32'h000000AA, 0);
    add_vec(0, 1, 3'b010, 9'h020, 32'h00000000, 32'h0, 0);
    add_vec(0, 1, 3'b001, 9'h022, 32'h00008001, 32'h0, 0);
    add_vec(1, 0, 3'b001, 9'h022, 32'h0, 32'hFFFF8001, 0);
    add_vec(1, 0, 3'b101, 9'h022, 32'h0, 32'h00008001, 0);
    add_vec(1, 0, 3'b010, 9'h020, 32'h0, 32'h80010000, 0);
    add_vec(1, 0, 3'b010, 9'h013, 32'h0, 32'h0, 1);
    add_vec(0, 1, 3'b001, 9'h021, 32'h0000FFFF, 32'h0, 1);
    add_vec(1, 0, 3'b010, 9'h020, 32'h0, 32'h80010000, 0);
    add_vec(1, 0, 3'b011, 9'h020, 32'h0, 32'h0, 1);
    add_vec(1, 1, 3'b010, 9'h030, 32'h12345678, 32'h0, 0);
    add_vec(1, 0, 3'b010, 9'h030, 32'h0, 32'h12345678, 0);
    add_vec(0, 1, 3'b011, 9'h030, 32'h0, 32'h0, 1);
    add_vec(1, 0, 3'b010, 9'h030, 32'h0, 32'h12345678, 0);
    add_vec(1, 0, 3'b001, 9'h032, 32'h0, 32'h00001234, 0);
    add_vec(1, 0, 3'b000, 9'h033, 32'h0, 32'h00000012, 0);
    add_vec(1, 0, 3'b000, 9'h030, 32'h0, 32'h00000078, 0);
    add_vec(1, 0, 3'b101, 9'h031, 32'h0, 32'h0, 1);
    add_vec(1, 0, 3'b110, 9'h030, 32'h0, 32'h0, 1);
    add_vec(0, 1, 3'b010, 9'h040, 32'h11111111, 32'h0, 0);

    foreach (vecs[i]) begin
      xact(vecs[i].rdop, vecs[i].wrop, vecs[i].f3, vecs[i].addr, vecs[i].wdat, r, f, l);
      chk($sformatf("vec%0d_rd", i), r, vecs[i].exp_rd);
      chk($sformatf("vec%0d_fault", i), 32'(f), 32'(vecs[i].exp_flt));
      chk($sformatf("vec%0d_latency", i), 32'(l), 32'(LAT));
      @(negedge clk);
      chk($sformatf("vec%0d_hold_rd", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_hold_fault", i), 32'(fault), 32'(vecs[i].exp_flt));
      model_op(vecs[i].rdop, vecs[i].wrop, vecs[i].f3, vecs[i].addr, vecs[i].wdat, er, ef);
    end

    abort_at(2);
    abort_at(4);

    // req_valid held high through a busy period: ready again at cycle WS+3.
    @(negedge clk);
    req_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; a = 9'h040;
    for (int k = 0; k <= LAT + 1; k++) begin
      chk($sformatf("busy_ready_c%0d", k), 32'(req_ready), 32'((k == 0) || (k == LAT + 1)));
      chk($sformatf("busy_resp_c%0d", k), 32'(resp_valid), 32'(k == LAT));
      if (k == LAT) chk("busy_rd", rd, 32'h11111111);
      if (k <= LAT) @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; MemRead = 1'b0;
    repeat (LAT + 2) @(negedge clk);

    // Give every word a known value, then random traffic against the model.
    for (int w = 0; w < 128; w++) begin
      d = $urandom;
      xact(1'b0, 1'b1, 3'b010, 9'(w * 4), d, r, f, l);
      model_op(1'b0, 1'b1, 3'b010, 9'(w * 4), d, er, ef);
    end
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 2);
      f3 = 3'($urandom_range(0, 7));
      ad = 9'($urandom_range(0, 511));
      d  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'b01) ad[0] = 1'b0;
        if (f3[1:0] == 2'b10) ad[1:0] = 2'b00;
      end
      model_op(op != 1, op != 0, f3, ad, d, er, ef);
      xact(op != 1, op != 0, f3, ad, d, r, f, l);
      chk($sformatf("rnd%0d_rd", i), r, er);
      chk($sformatf("rnd%0d_fault", i), 32'(f), 32'(ef));
      chk($sformatf("rnd%0d_latency", i), 32'(l), 32'(LAT));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The block SHALL provide parameter DM_ADDRESS, default 9, byte-address width; memory depth is 2^(DM_ADDRESS-2) 32-bit words.
REQ-002 The block SHALL provide parameter WAIT_STATES, default 0, range 0..7, extra access cycles inserted before the memory access.
REQ-003 The block SHALL provide port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 The block SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL provide port req_valid  input  1  request present.
REQ-006 The block SHALL provide port req_ready  output  1  block can accept a request this cycle.
REQ-007 The block SHALL provide port MemRead  input  1  load request (from control unit).
REQ-008 The block SHALL provide port MemWrite  input  1  store request (from control unit).
REQ-009 The block SHALL provide port a  input  DM_ADDRESS  byte address (ALU output LSBs).
REQ-010 The block SHALL provide port wd  input  32  store data.
REQ-011 The block SHALL provide port Funct3  input  3  instruction bits 14:12, access size/sign.
REQ-012 The block SHALL provide port rd  output  32  load data, registered.
REQ-013 The block SHALL provide port resp_valid  output  1  one-cycle response pulse.
REQ-014 The block SHALL provide port fault  output  1  response flags misaligned or unsupported access; valid with resp_valid.

Function
REQ-015 The block SHALL implement FSM states IDLE, WAIT, ACCESS, RESP; req_ready=1 only in IDLE.
REQ-016 A request SHALL be accepted when req_valid & req_ready & (MemRead | MemWrite); a, wd, Funct3 and the op are captured at that edge.
REQ-017 With req_valid high but MemRead=MemWrite=0, the block SHALL NOT accept and SHALL stay in IDLE.
REQ-018 If MemRead and MemWrite are both high at acceptance, the block SHALL perform the store only.
REQ-019 After acceptance (cycle 0), the FSM SHALL spend WAIT_STATES cycles in WAIT (down-counter), 1 cycle in ACCESS, 1 cycle in RESP, then return to IDLE; resp_valid=1 only in RESP, i.e. cycle WAIT_STATES+2.
REQ-020 Next request acceptance SHALL be possible no earlier than cycle WAIT_STATES+3.
REQ-021 Supported loads SHALL be LB 000, LH 001, LW 010, LBU 100, LHU 101; supported stores SB 000, SH 001, SW 010.
REQ-022 Word index SHALL be a[DM_ADDRESS-1:2]; byte lane a[1:0]; halfword lane a[1].
REQ-023 LB/LH SHALL sign-extend, LBU/LHU SHALL zero-extend the selected lane to 32 bits; LW returns the full word.
REQ-024 SB SHALL write only lane a[1:0] with wd[7:0]; SH only lanes {a[1],0},{a[1],1} with wd[15:0]; SW all four lanes; unwritten lanes SHALL be unchanged.
REQ-025 Stores SHALL commit at the clock edge ending ACCESS; a load issued after a store's resp_valid SHALL observe the stored data.
REQ-026 Halfword access with a[0]=1, word access with a[1:0]!=0, or unsupported Funct3 SHALL set fault=1 in RESP, perform no memory write, and return rd=0.
REQ-027 Stores SHALL return rd=0 with fault=0 when legal.
REQ-028 rd and fault SHALL hold their RESP values until the next RESP cycle.
REQ-029 Memory contents SHALL NOT be initialised by reset; contents are undefined until written.

Reset
REQ-030 While rst=1 at a clock edge, the FSM SHALL go to IDLE, clear the wait counter, and drive resp_valid=0, rd=0, fault=0; req_ready=1 from the first cycle after reset.
REQ-031 Reset asserted in WAIT or ACCESS SHALL abort the request: no memory write, no response.

Verification
REQ-032 SW a=0x010 wd=0xDEADBEEF, then LW a=0x010 -> rd=0xDEADBEEF, fault=0, resp_valid exactly WAIT_STATES+2 cycles after each acceptance.
REQ-033 After REQ-032 word: SB a=0x011 wd=0x000000AA, then LW a=0x010 -> rd=0xDEADAAEF; LB a=0x011 -> 0xFFFFFFAA; LBU a=0x011 -> 0x000000AA.
REQ-034 SH a=0x022 wd=0x00008001 over zeroed word, LH a=0x022 -> 0xFFFF8001, LHU -> 0x00008001, LW a=0x020 -> 0x80010000.
REQ-035 LW a=0x013 and SH a=0x021 -> fault=1, rd=0; subsequent LW a=0x020 unchanged; Funct3=011 load -> fault=1.
REQ-036 WAIT_STATES=3: SW accepted, rst pulsed in cycle 2 -> no resp_valid, word unchanged on later LW; req_valid held high during busy -> req_ready=0 until IDLE, second request accepted at cycle 6.
